// File: rtl/seg_scan_mux.sv
// Time-multiplexed 8-digit 7-segment scanner with per-slot blanking,
// running-player decimal point and end-of-game whole-display blink.
module seg_scan_mux #(
  parameter int REFRESH_DIV  = 32'd12500,
  parameter int BLANK_CYC    = 32'd16,
  parameter int BLINK_FRAMES = 32'd64,
  parameter int ACTIVE_LOW   = 32'd1
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  input  logic [6:0] seg0_0,
  input  logic [6:0] seg0_1,
  input  logic [6:0] seg0_2,
  input  logic [6:0] seg0_3,
  input  logic [6:0] seg1_0,
  input  logic [6:0] seg1_1,
  input  logic [6:0] seg1_2,
  input  logic [6:0] seg1_3,
  input  logic       ACTIVE_P1,
  input  logic       ACTIVE_P2,
  input  logic       BLINK_EN,
  output logic [6:0] SEG_OUT,
  output logic       DP_OUT,
  output logic [7:0] AN,
  output logic [2:0] SCAN_IDX
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam int FW = $clog2(BLINK_FRAMES + 32'd1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 32'd1);
  localparam logic [SW-1:0] BLANK_V    = SW'(BLANK_CYC);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 32'd1);
  localparam logic          POL        = (ACTIVE_LOW != 32'd0) ? 1'b1 : 1'b0;

  logic [SW-1:0] slot_cnt_r;
  logic [2:0]    idx_r;
  logic [FW-1:0] frame_cnt_r;
  logic          blink_ph_r;
  logic [6:0]    cap_r;
  logic [6:0]    seg_out_r;
  logic          dp_out_r;
  logic [7:0]    an_r;
  logic [2:0]    scan_idx_r;

  logic [6:0]    sel_s;
  logic          lit_s;
  logic          en_s;
  logic [7:0]    an_nxt_s;
  logic [6:0]    seg_nxt_s;
  logic          dp_nxt_s;

  // Select the digit pattern addressed by the current scan index
  always_comb begin
    sel_s = 7'd0;
    case (idx_r)
      3'd0:    sel_s = seg0_0;
      3'd1:    sel_s = seg0_1;
      3'd2:    sel_s = seg0_2;
      3'd3:    sel_s = seg0_3;
      3'd4:    sel_s = seg1_0;
      3'd5:    sel_s = seg1_1;
      3'd6:    sel_s = seg1_2;
      3'd7:    sel_s = seg1_3;
      default: sel_s = 7'd0;
    endcase
  end

  // Next output values in active-high form, derived from the present counter state
  always_comb begin
    lit_s     = (slot_cnt_r >= BLANK_V);
    en_s      = lit_s && !(BLINK_EN && blink_ph_r);
    an_nxt_s  = 8'd0;
    seg_nxt_s = 7'd0;
    dp_nxt_s  = 1'b0;
    if (en_s) begin
      an_nxt_s = 8'd1 << idx_r;
      dp_nxt_s = ((idx_r == 3'd1) && ACTIVE_P1) || ((idx_r == 3'd5) && ACTIVE_P2);
    end else begin
      an_nxt_s = 8'd0;
      dp_nxt_s = 1'b0;
    end
    if (lit_s) begin
      seg_nxt_s = cap_r;
    end else begin
      seg_nxt_s = 7'd0;
    end
  end

  // Slot, digit, frame and blink counters plus the per-slot pattern capture
  always_ff @(posedge CLK) begin
    if (CLR) begin
      slot_cnt_r  <= '0;
      idx_r       <= 3'd0;
      frame_cnt_r <= '0;
      blink_ph_r  <= 1'b0;
      cap_r       <= 7'd0;
    end else if (CE) begin
      if (slot_cnt_r == '0) begin
        cap_r <= sel_s;
      end
      if (slot_cnt_r == SLOT_LAST) begin
        slot_cnt_r <= '0;
        idx_r      <= idx_r + 3'd1;
        if (idx_r == 3'd7) begin
          if (frame_cnt_r == FRAME_LAST) begin
            frame_cnt_r <= '0;
            blink_ph_r  <= ~blink_ph_r;
          end else begin
            frame_cnt_r <= frame_cnt_r + {{(FW-1){1'b0}}, 1'b1};
          end
        end
      end else begin
        slot_cnt_r <= slot_cnt_r + {{(SW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Registered, polarity-converted display outputs
  always_ff @(posedge CLK) begin
    if (CLR) begin
      seg_out_r  <= {7{POL}};
      dp_out_r   <= POL;
      an_r       <= {8{POL}};
      scan_idx_r <= 3'd0;
    end else if (CE) begin
      seg_out_r  <= seg_nxt_s ^ {7{POL}};
      dp_out_r   <= dp_nxt_s ^ POL;
      an_r       <= an_nxt_s ^ {8{POL}};
      scan_idx_r <= idx_r;
    end
  end

  assign SEG_OUT  = seg_out_r;
  assign DP_OUT   = dp_out_r;
  assign AN       = an_r;
  assign SCAN_IDX = scan_idx_r;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized bench for seg_scan_mux against a time-based reference model
// (scan position derived arithmetically from the count of enabled cycles).
module tb_seg_scan_mux;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       clr, ce, p1, p2, blink;
  logic [6:0] seg_in [8];
  logic [6:0] seg_out;
  logic       dp_out;
  logic [7:0] an;
  logic [2:0] scan_idx;

  int         vectors = 0;
  int         miscompares = 0;

  int         t;
  logic [6:0] cap;
  logic [7:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  logic [2:0] e_idx;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .REFRESH_DIV(RD), .BLANK_CYC(BC), .BLINK_FRAMES(BF), .ACTIVE_LOW(1)
  ) dut (
    .CLK(clk), .CLR(clr), .CE(ce),
    .seg0_0(seg_in[0]), .seg0_1(seg_in[1]), .seg0_2(seg_in[2]), .seg0_3(seg_in[3]),
    .seg1_0(seg_in[4]), .seg1_1(seg_in[5]), .seg1_2(seg_in[6]), .seg1_3(seg_in[7]),
    .ACTIVE_P1(p1), .ACTIVE_P2(p2), .BLINK_EN(blink),
    .SEG_OUT(seg_out), .DP_OUT(dp_out), .AN(an), .SCAN_IDX(scan_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs for the coming edge, then advance the model
  task automatic model_step();
    int   slot, idx, ph;
    logic act;
    logic [7:0] one;
    if (clr) begin
      t = 0; cap = 7'h00;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_idx = 3'd0;
    end else if (ce) begin
      slot = t % RD;
      idx  = (t / RD) % 8;
      ph   = ((t / (RD * 8)) / BF) % 2;
      act  = (slot >= BC) && !(blink && (ph == 1));
      one  = 8'h01 << idx;
      e_an  = act ? ~one : 8'hFF;
      e_seg = (slot >= BC) ? ~cap : 7'h7F;
      e_dp  = !(act && ((idx == 1 && p1) || (idx == 5 && p2)));
      e_idx = idx[2:0];
      if (slot == 0) cap = seg_in[idx];
      t++;
    end
  endtask

  initial begin
    clr = 1'b1; ce = 1'b1; p1 = 1'b0; p2 = 1'b1; blink = 1'b0;
    for (int k = 0; k < 4; k++) begin
      seg_in[k]     = 7'h01 << k;
      seg_in[k + 4] = 7'h10 + 7'(k);
    end
    t = 0; cap = 7'h00;
    e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_idx = 3'd0;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      clr = (i < 3) || ($urandom_range(0, 599) == 0);
      if (i < 100)                 ce = 1'b1;
      else if (i >= 700 && i < 720) ce = 1'b0;
      else                         ce = ($urandom_range(0, 7) != 0);
      blink = (i >= 1000 && i < 2400);
      if (i >= 100 && $urandom_range(0, 3) == 0)
        seg_in[$urandom_range(0, 7)] = 7'($urandom);
      if ($urandom_range(0, 19) == 0) p1 = ~p1;
      if ($urandom_range(0, 19) == 0) p2 = ~p2;
      model_step();
      @(posedge clk);
      #1;
      check("an", 32'(an), 32'(e_an));
      check("seg_out", 32'(seg_out), 32'(e_seg));
      check("dp_out", 32'(dp_out), 32'(e_dp));
      check("scan_idx", 32'(scan_idx), 32'(e_idx));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
